// File: rtl/serial_carry_bypass_subtractor.sv
// Multi-cycle subtractor: D = A - B - Bin evaluated as A + ~B + ~Bin, one carry-bypass block per clock.
// Valid/ready handshake on both sides; the borrow (BF) and signed overflow (OF) flags are set on the last block.
module serial_carry_bypass_subtractor #(
  parameter int DATA_WIDTH = 4,
  parameter int BLOCK_SIZE = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Bin,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  BF,
  output logic                  OF,
  output logic                  Out_Valid,
  input  logic                  Out_Ready
);

  localparam int NUM_BLOCKS = DATA_WIDTH / BLOCK_SIZE;
  localparam int CNT_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int MSB        = DATA_WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] nb_r;
  logic                  carry_r;
  logic [BLOCK_SIZE-1:0] d_blk_r  [NUM_BLOCKS];
  logic [BLOCK_SIZE-1:0] a_blk_s  [NUM_BLOCKS];
  logic [BLOCK_SIZE-1:0] nb_blk_s [NUM_BLOCKS];

  logic [BLOCK_SIZE-1:0] blk_a_s;
  logic [BLOCK_SIZE-1:0] blk_nb_s;
  logic [BLOCK_SIZE-1:0] p_s;
  logic [BLOCK_SIZE-1:0] g_s;
  logic [BLOCK_SIZE-1:0] sum_s;
  logic                  rc_s;
  logic                  carry_out_s;

  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
    assign a_blk_s[k]                      = a_r[k*BLOCK_SIZE +: BLOCK_SIZE];
    assign nb_blk_s[k]                     = nb_r[k*BLOCK_SIZE +: BLOCK_SIZE];
    assign D[k*BLOCK_SIZE +: BLOCK_SIZE]   = d_blk_r[k];
  end

  assign In_Ready  = (state_r == IDLE);
  assign Out_Valid = (state_r == HOLD);

  // Current block: ripple sum plus carry-out, bypassed when every bit propagates
  always_comb begin
    blk_a_s  = a_blk_s[cnt_r];
    blk_nb_s = nb_blk_s[cnt_r];
    p_s      = blk_a_s ^ blk_nb_s;
    g_s      = blk_a_s & blk_nb_s;
    sum_s    = '0;
    rc_s     = carry_r;
    for (int i = 0; i < BLOCK_SIZE; i++) begin
      sum_s[i] = p_s[i] ^ rc_s;
      rc_s     = g_s[i] | (p_s[i] & rc_s);
    end
    if (&p_s) begin
      carry_out_s = carry_r;
    end else begin
      carry_out_s = rc_s;
    end
  end

  // Control FSM, operand capture and result/flag registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      nb_r    <= '0;
      carry_r <= 1'b0;
      BF      <= 1'b0;
      OF      <= 1'b0;
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        d_blk_r[k] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (In_Valid) begin
            a_r     <= A;
            nb_r    <= ~B;
            carry_r <= ~Bin;
            cnt_r   <= '0;
            state_r <= CALC;
          end
        end
        CALC: begin
          d_blk_r[cnt_r] <= sum_s;
          carry_r        <= carry_out_s;
          if (cnt_r == LAST_BLK) begin
            // Borrow is the inverted final carry; overflow compares against the true B sign (~nb_r)
            BF      <= ~carry_out_s;
            OF      <= (a_r[MSB] == nb_r[MSB]) && (sum_s[BLOCK_SIZE-1] != a_r[MSB]);
            state_r <= HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        HOLD: begin
          if (Out_Ready) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_carry_bypass_subtractor.sv
// Scoreboard bench: a 4-bit/1-bit-block instance plus two 8-bit instances (2- and 4-bit blocks) fed in lockstep.
module tb_serial_carry_bypass_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       bf;
    logic       of;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst;
  int         cyc;
  int         total;
  int         bad;

  logic [3:0] a4, b4, d4;
  logic       bin4, iv4, ir4, bf4, of4, ov4, or4, pv4;
  logic [7:0] a8, b8, d8a, d8b;
  logic       bin8, iv8, or8;
  logic       ir8a, bf8a, of8a, ov8a, pv8a;
  logic       ir8b, bf8b, of8b, ov8b, pv8b;

  exp_t q4[$];
  exp_t q8a[$];
  exp_t q8b[$];

  serial_carry_bypass_subtractor #(.DATA_WIDTH(4), .BLOCK_SIZE(1)) u_dut4 (
    .CLK(clk), .RST(rst), .A(a4), .B(b4), .Bin(bin4), .In_Valid(iv4), .In_Ready(ir4),
    .D(d4), .BF(bf4), .OF(of4), .Out_Valid(ov4), .Out_Ready(or4)
  );

  serial_carry_bypass_subtractor #(.DATA_WIDTH(8), .BLOCK_SIZE(2)) u_dut8a (
    .CLK(clk), .RST(rst), .A(a8), .B(b8), .Bin(bin8), .In_Valid(iv8), .In_Ready(ir8a),
    .D(d8a), .BF(bf8a), .OF(of8a), .Out_Valid(ov8a), .Out_Ready(or8)
  );

  serial_carry_bypass_subtractor #(.DATA_WIDTH(8), .BLOCK_SIZE(4)) u_dut8b (
    .CLK(clk), .RST(rst), .A(a8), .B(b8), .Bin(bin8), .In_Valid(iv8), .In_Ready(ir8b),
    .D(d8b), .BF(bf8b), .OF(of8b), .Out_Valid(ov8b), .Out_Ready(or8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, borrow from sign, overflow from operand/result signs
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input int acc);
    exp_t e;
    int   diff;
    diff  = int'(a) - int'(b) - int'(bin);
    e.d   = 8'(diff & ((1 << w) - 1));
    e.bf  = (diff < 0);
    e.of  = (a[w-1] != b[w-1]) && (e.d[w-1] != a[w-1]);
    e.acc = acc;
    return e;
  endfunction

  // Compare on the first cycle each instance shows a result
  always @(negedge clk) begin
    exp_t e;
    if (ov4 && !pv4) begin
      if (q4.size() == 0) check("q4_unexpected", 32'd1, 32'd0);
      else begin
        e = q4.pop_front();
        check("d4", 32'(d4), 32'(e.d));
        check("bf4", 32'(bf4), 32'(e.bf));
        check("of4", 32'(of4), 32'(e.of));
        check("lat4", 32'(cyc - e.acc), 32'd4);
      end
    end
    pv4 = ov4;
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov8a && !pv8a) begin
      if (q8a.size() == 0) check("q8a_unexpected", 32'd1, 32'd0);
      else begin
        e = q8a.pop_front();
        check("d8a", 32'(d8a), 32'(e.d));
        check("bf8a", 32'(bf8a), 32'(e.bf));
        check("of8a", 32'(of8a), 32'(e.of));
        check("lat8a", 32'(cyc - e.acc), 32'd4);
      end
    end
    pv8a = ov8a;
  end

  always @(negedge clk) begin
    exp_t e;
    if (ov8b && !pv8b) begin
      if (q8b.size() == 0) check("q8b_unexpected", 32'd1, 32'd0);
      else begin
        e = q8b.pop_front();
        check("d8b", 32'(d8b), 32'(e.d));
        check("bf8b", 32'(bf8b), 32'(e.bf));
        check("of8b", 32'(of8b), 32'(e.of));
        check("lat8b", 32'(cyc - e.acc), 32'd2);
      end
    end
    pv8b = ov8b;
  end

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int n;
    n = 0;
    @(negedge clk);
    while (!ir4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ir4) check("ir4_timeout", 32'd0, 32'd1);
    a4   = a;
    b4   = b;
    bin4 = bin;
    iv4  = 1'b1;
    q4.push_back(model(4, {4'd0, a}, {4'd0, b}, bin, cyc + 1));
    @(negedge clk);
    iv4 = 1'b0;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int n;
    n = 0;
    @(negedge clk);
    while (!(ir8a && ir8b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!(ir8a && ir8b)) check("ir8_timeout", 32'd0, 32'd1);
    a8   = a;
    b8   = b;
    bin8 = bin;
    iv8  = 1'b1;
    q8a.push_back(model(8, a, b, bin, cyc + 1));
    q8b.push_back(model(8, a, b, bin, cyc + 1));
    @(negedge clk);
    iv8 = 1'b0;
  endtask

  initial begin
    exp_t eh;
    int   n;
    total = 0;
    bad   = 0;
    pv4 = 1'b0; pv8a = 1'b0; pv8b = 1'b0;
    a4 = 4'd0; b4 = 4'd0; bin4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;
    a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_d4", 32'(d4), 32'd0);
    check("rst_flags4", 32'({bf4, of4}), 32'd0);
    check("rst_ov4", 32'(ov4), 32'd0);
    check("rst_ir4", 32'(ir4), 32'd1);
    check("rst_ov8", 32'({ov8a, ov8b}), 32'd0);
    check("rst_ir8", 32'({ir8a, ir8b}), 32'd3);
    rst = 1'b0;

    send4(4'b0101, 4'b0011, 1'b0);
    send4(4'b0001, 4'b0100, 1'b0);
    send4(4'b1000, 4'b0001, 1'b0);
    send4(4'b0111, 4'b1111, 1'b0);
    send4(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 12; i++) send4(4'($urandom), 4'($urandom), 1'($urandom));

    // Stall in HOLD while operands and In_Valid wiggle
    n = 0;
    while (!ir4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    or4 = 1'b0;
    eh  = model(4, 8'h06, 8'h09, 1'b1, 0);
    send4(4'b0110, 4'b1001, 1'b1);
    n = 0;
    while (!ov4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", 32'(ov4), 32'd1);
    for (int i = 0; i < 10; i++) begin
      a4   = 4'($urandom);
      b4   = 4'($urandom);
      bin4 = 1'($urandom);
      iv4  = 1'(i % 2);
      @(negedge clk);
      check("hold_ov", 32'(ov4), 32'd1);
      check("hold_ir", 32'(ir4), 32'd0);
      check("hold_d", 32'(d4), 32'(eh.d));
      check("hold_flags", 32'({bf4, of4}), 32'({eh.bf, eh.of}));
    end
    iv4 = 1'b0;
    or4 = 1'b1;
    @(negedge clk);
    check("exit_ov", 32'(ov4), 32'd0);
    check("exit_ir", 32'(ir4), 32'd1);
    check("idle_keep_d", 32'(d4), 32'(eh.d));

    // Abort in the second CALC cycle
    send4(4'b1010, 4'b0101, 1'b0);
    @(negedge clk);
    check("pre_rst_ov", 32'(ov4), 32'd0);
    rst = 1'b1;
    #1;
    check("arst_d", 32'(d4), 32'd0);
    check("arst_flags", 32'({bf4, of4}), 32'd0);
    check("arst_ov", 32'(ov4), 32'd0);
    check("arst_ir", 32'(ir4), 32'd1);
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    send4(4'b0101, 4'b0011, 1'b0);
    send4(4'b0011, 4'b0101, 1'b1);

    // 8-bit instances, corners then random
    send8(8'h00, 8'h00, 1'b0);
    send8(8'h00, 8'h00, 1'b1);
    send8(8'hFF, 8'h00, 1'b1);
    send8(8'h80, 8'h01, 1'b0);
    send8(8'h7F, 8'hFF, 1'b0);
    send8(8'h55, 8'hAA, 1'b1);
    for (int i = 0; i < 40; i++) send8(8'($urandom), 8'($urandom), 1'($urandom));

    n = 0;
    while ((q4.size() + q8a.size() + q8b.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q4.size() + q8a.size() + q8b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
